// File: rtl/sprite_compositor_if.sv
// Pixel stream into the compositor and composited video stream out of it.
// The master side is the raster/timing source; the slave side is the compositor.
interface sprite_compositor_if #(
  parameter int IDW = 2
);
  logic           pixel_valid;
  logic [9:0]     DrawX;
  logic [9:0]     DrawY;
  logic           frame_start;
  logic [23:0]    bg_rgb;
  logic [7:0]     VGA_R;
  logic [7:0]     VGA_G;
  logic [7:0]     VGA_B;
  logic           out_valid;
  logic           hit_valid;
  logic [IDW-1:0] hit_id;

  modport master (
    output pixel_valid, DrawX, DrawY, frame_start, bg_rgb,
    input  VGA_R, VGA_G, VGA_B, out_valid, hit_valid, hit_id
  );

  modport slave (
    input  pixel_valid, DrawX, DrawY, frame_start, bg_rgb,
    output VGA_R, VGA_G, VGA_B, out_valid, hit_valid, hit_id
  );
endinterface

// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES oriented, key-coloured sprites over a background colour.
// Three-stage pipeline: hit test / ROM address, ROM read, priority select / collision.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPRITE_W    = 32,
  parameter int          ADDR_W      = 10,
  parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
  parameter int          IDW         = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  sprite_compositor_if.slave            pix,
  input  logic [NUM_SPRITES-1:0]        sprite_en,
  input  logic [10*NUM_SPRITES-1:0]     sprite_x,
  input  logic [10*NUM_SPRITES-1:0]     sprite_y,
  input  logic [2*NUM_SPRITES-1:0]      sprite_dir,
  output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
  input  logic [24*NUM_SPRITES-1:0]     rom_data,
  output logic [NUM_SPRITES-1:0]        collision_flags
);

  localparam int              LOG_W = $clog2(SPRITE_W);
  localparam logic [LOG_W-1:0] N_MAX = LOG_W'(SPRITE_W - 1);

  // Hit test plus orientation-aware ROM address; returns {hit, address}.
  // Bounds use 11-bit sums so a sprite near column 1023 never wraps to column 0.
  function automatic logic [ADDR_W:0] locate(
    input logic       en,
    input logic       pv,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [9:0] sx,
    input logic [9:0] sy,
    input logic [1:0] dir
  );
    logic [10:0]      x11;
    logic [10:0]      y11;
    logic [10:0]      sx11;
    logic [10:0]      sy11;
    logic             hit;
    logic [LOG_W-1:0] u;
    logic [LOG_W-1:0] v;
    logic [LOG_W-1:0] su;
    logic [LOG_W-1:0] sv;
    x11  = {1'b0, x};
    y11  = {1'b0, y};
    sx11 = {1'b0, sx};
    sy11 = {1'b0, sy};
    hit  = en & pv & (x11 >= sx11) & (x11 < sx11 + 11'(SPRITE_W))
                   & (y11 >= sy11) & (y11 < sy11 + 11'(SPRITE_W));
    u = LOG_W'(x - sx);
    v = LOG_W'(y - sy);
    case (dir)
      2'b00:   begin su = u;         sv = v;         end
      2'b01:   begin su = v;         sv = N_MAX - u; end
      2'b10:   begin su = N_MAX - u; sv = N_MAX - v; end
      2'b11:   begin su = N_MAX - v; sv = u;         end
      default: begin su = u;         sv = v;         end
    endcase
    return hit ? {1'b1, ADDR_W'({sv, su})} : {1'b0, {ADDR_W{1'b0}}};
  endfunction

  logic [NUM_SPRITES-1:0]        hit_s;
  logic [ADDR_W*NUM_SPRITES-1:0] addr_s;
  logic [ADDR_W*NUM_SPRITES-1:0] rom_addr_r;
  logic [NUM_SPRITES-1:0]        hit1_r;
  logic [NUM_SPRITES-1:0]        hit2_r;
  logic [23:0]                   bg1_r;
  logic [23:0]                   bg2_r;
  logic                          valid1_r;
  logic                          valid2_r;

  // Per-sprite hit and source address for the incoming pixel
  always_comb begin
    hit_s  = '0;
    addr_s = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      {hit_s[i], addr_s[ADDR_W*i +: ADDR_W]} = locate(sprite_en[i], pix.pixel_valid,
                                                      pix.DrawX, pix.DrawY,
                                                      sprite_x[10*i +: 10],
                                                      sprite_y[10*i +: 10],
                                                      sprite_dir[2*i +: 2]);
    end
  end

  // Stages 1 and 2: ROM address register and alignment of hit/bg/valid with ROM data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_r <= '0;
      hit1_r     <= '0;
      hit2_r     <= '0;
      bg1_r      <= 24'h000000;
      bg2_r      <= 24'h000000;
      valid1_r   <= 1'b0;
      valid2_r   <= 1'b0;
    end else begin
      rom_addr_r <= addr_s;
      hit1_r     <= hit_s;
      bg1_r      <= pix.bg_rgb;
      valid1_r   <= pix.pixel_valid;
      hit2_r     <= hit1_r;
      bg2_r      <= bg1_r;
      valid2_r   <= valid1_r;
    end
  end

  assign rom_addr = rom_addr_r;

  logic [NUM_SPRITES-1:0] opaque_s;
  logic                   win_s;
  logic [IDW-1:0]         win_id_s;
  logic [23:0]            win_rgb_s;
  logic                   collide_s;

  // Lowest-index opaque sprite wins; scanning downwards lets the lowest index land last
  always_comb begin
    opaque_s  = '0;
    win_s     = 1'b0;
    win_id_s  = '0;
    win_rgb_s = bg2_r;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque_s[i] = valid2_r & hit2_r[i] & (rom_data[24*i +: 24] != KEY_COLOR);
      win_s       = opaque_s[i] ? 1'b1                 : win_s;
      win_id_s    = opaque_s[i] ? IDW'(i)              : win_id_s;
      win_rgb_s   = opaque_s[i] ? rom_data[24*i +: 24] : win_rgb_s;
    end
    // x & (x-1) is nonzero exactly when two or more bits are set
    collide_s = |(opaque_s & (opaque_s - NUM_SPRITES'(1'b1)));
  end

  logic [23:0]            rgb_r;
  logic                   out_valid_r;
  logic                   hit_valid_r;
  logic [IDW-1:0]         hit_id_r;
  logic [NUM_SPRITES-1:0] flags_r;

  // Stage 3: output colour, winner report and sticky per-frame collision flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_r       <= 24'h000000;
      out_valid_r <= 1'b0;
      hit_valid_r <= 1'b0;
      hit_id_r    <= '0;
      flags_r     <= '0;
    end else begin
      out_valid_r <= valid2_r;
      if (valid2_r) begin
        rgb_r       <= win_rgb_s;
        hit_valid_r <= win_s;
        hit_id_r    <= win_id_s;
      end else begin
        rgb_r       <= 24'h000000;
        hit_valid_r <= 1'b0;
        hit_id_r    <= '0;
      end
      // A collision on the frame_start edge belongs to the new frame
      if (collide_s) begin
        flags_r <= (pix.frame_start ? '0 : flags_r) | opaque_s;
      end else if (pix.frame_start) begin
        flags_r <= '0;
      end else begin
        flags_r <= flags_r;
      end
    end
  end

  assign pix.VGA_R      = rgb_r[23:16];
  assign pix.VGA_G      = rgb_r[15:8];
  assign pix.VGA_B      = rgb_r[7:0];
  assign pix.out_valid  = out_valid_r;
  assign pix.hit_valid  = hit_valid_r;
  assign pix.hit_id     = hit_id_r;
  assign collision_flags = flags_r;

endmodule
